// File: rtl/retire_if.sv
// Scheduler-side bundle: reservation-station retire requests/fields in,
// one-hot grant out, plus the valid/ready writeback port toward the register file.
interface retire_if #(
    parameter int RS_COUNT   = 3,
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32
);
    logic [RS_COUNT-1:0]                 ReadyToRetire;
    logic [RS_COUNT-1:0]                 retire_write_enable_units;
    logic [RS_COUNT-1:0][REG_ADDR_W-1:0] retire_write_units;
    logic [RS_COUNT-1:0][DATA_W-1:0]     retire_write_value_units;
    logic [RS_COUNT-1:0]                 DoRetire;
    logic                                flush;
    logic                                wb_valid;
    logic                                wb_ready;
    logic                                wb_write_enable;
    logic [REG_ADDR_W-1:0]               wb_register;
    logic [DATA_W-1:0]                   wb_value;
    logic [31:0]                         retired_count;

    modport master (
        input  ReadyToRetire, retire_write_enable_units, retire_write_units,
               retire_write_value_units, flush, wb_ready,
        output DoRetire, wb_valid, wb_write_enable, wb_register, wb_value,
               retired_count
    );

    modport slave (
        output ReadyToRetire, retire_write_enable_units, retire_write_units,
               retire_write_value_units, flush, wb_ready,
        input  DoRetire, wb_valid, wb_write_enable, wb_register, wb_value,
               retired_count
    );
endinterface

// File: rtl/retire_scheduler.sv
// Round-robin retirement arbiter feeding a one-entry writeback stage; a station is
// granted only when the stage can take its fields on the same clock edge.
module retire_scheduler #(
    parameter int RS_COUNT   = 3,
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32
) (
    input logic    clk,
    input logic    rst_n,
    retire_if.master bus
);
    localparam int PTR_W = (RS_COUNT > 1) ? $clog2(RS_COUNT) : 1;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  wb_we_q, wb_we_d;
    logic [REG_ADDR_W-1:0] wb_reg_q, wb_reg_d;
    logic [DATA_W-1:0]     wb_val_q, wb_val_d;
    logic [31:0]           count_q, count_d;

    logic                  accept;
    logic                  can_load;
    logic                  found;
    logic [PTR_W-1:0]      winner;
    logic                  grant;
    logic [RS_COUNT-1:0]   do_retire;

    // Returns {found, index} of the first requester at or after ptr, wrapping.
    function automatic logic [PTR_W:0] rr_pick(input logic [RS_COUNT-1:0] req,
                                               input logic [PTR_W-1:0]    ptr);
        logic             hit;
        logic [PTR_W-1:0] win;
        logic [PTR_W-1:0] idx;
        hit = 1'b0;
        win = '0;
        for (int i = 0; i < RS_COUNT; i++) begin
            idx = PTR_W'((int'(ptr) + i) % RS_COUNT);
            if (!hit && req[idx]) begin
                hit = 1'b1;
                win = idx;
            end
        end
        return {hit, win};
    endfunction

    always_comb begin
        accept    = (state_q == FULL) && bus.wb_ready;
        can_load  = !bus.flush && ((state_q == EMPTY) || accept);
        {found, winner} = rr_pick(bus.ReadyToRetire, rr_ptr_q);
        grant     = can_load && found && rst_n;
        do_retire = '0;
        if (grant) do_retire[winner] = 1'b1;

        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        wb_we_d  = wb_we_q;
        wb_reg_d = wb_reg_q;
        wb_val_d = wb_val_q;
        count_d  = count_q + 32'(accept);

        if (bus.flush) begin
            state_d = EMPTY;
            wb_we_d = 1'b0;
        end else if (grant) begin
            state_d  = FULL;
            wb_reg_d = bus.retire_write_units[winner];
            wb_val_d = bus.retire_write_value_units[winner];
            // x0 is hard-wired zero: the entry still retires but never writes.
            wb_we_d  = bus.retire_write_enable_units[winner] &&
                       (bus.retire_write_units[winner] != '0);
            rr_ptr_d = (winner == PTR_W'(RS_COUNT - 1)) ? '0 : winner + 1'b1;
        end else if (accept) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            rr_ptr_q <= '0;
            wb_we_q  <= 1'b0;
            wb_reg_q <= '0;
            wb_val_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            wb_we_q  <= wb_we_d;
            wb_reg_q <= wb_reg_d;
            wb_val_q <= wb_val_d;
            count_q  <= count_d;
        end
    end

    assign bus.DoRetire        = do_retire;
    assign bus.wb_valid        = (state_q == FULL);
    assign bus.wb_write_enable = wb_we_q;
    assign bus.wb_register     = wb_reg_q;
    assign bus.wb_value        = wb_val_q;
    assign bus.retired_count   = count_q;
endmodule

// File: tb/tb_retire_scheduler.sv
// Directed bench for retire_scheduler: round-robin order, stall, x0, flush,
// fairness between two requesters and asynchronous reset.
module tb_retire_scheduler;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    retire_if #(.RS_COUNT(3), .REG_ADDR_W(5), .DATA_W(32)) bus ();

    retire_scheduler #(.RS_COUNT(3), .REG_ADDR_W(5), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.ReadyToRetire             = 3'b111;
        bus.retire_write_enable_units = 3'b111;
        bus.retire_write_units[0]     = 5'd1;
        bus.retire_write_units[1]     = 5'd2;
        bus.retire_write_units[2]     = 5'd3;
        bus.retire_write_value_units[0] = 32'h100;
        bus.retire_write_value_units[1] = 32'h101;
        bus.retire_write_value_units[2] = 32'h102;
        bus.flush    = 1'b0;
        bus.wb_ready = 1'b0;
        #1;
        check("rst_doretire", 32'(bus.DoRetire), 32'h0);
        check("rst_valid", 32'(bus.wb_valid), 32'h0);
        check("rst_we", 32'(bus.wb_write_enable), 32'h0);
        check("rst_reg", 32'(bus.wb_register), 32'h0);
        check("rst_value", bus.wb_value, 32'h0);
        check("rst_count", bus.retired_count, 32'h0);
        bus.ReadyToRetire = 3'b000;
        #2;
        rst_n = 1'b1;

        // Round-robin across all three stations
        cyc();
        bus.ReadyToRetire = 3'b111;
        bus.wb_ready      = 1'b1;
        #1;
        check("rr_grant0", 32'(bus.DoRetire), 32'b001);
        cyc(); #1;
        check("rr_grant1", 32'(bus.DoRetire), 32'b010);
        check("rr_valid1", 32'(bus.wb_valid), 32'h1);
        check("rr_reg1", 32'(bus.wb_register), 32'd1);
        check("rr_value1", bus.wb_value, 32'h100);
        check("rr_count1", bus.retired_count, 32'd0);
        cyc(); #1;
        check("rr_grant2", 32'(bus.DoRetire), 32'b100);
        check("rr_reg2", 32'(bus.wb_register), 32'd2);
        check("rr_count2", bus.retired_count, 32'd1);
        cyc();
        bus.ReadyToRetire = 3'b000;
        #1;
        check("rr_nogrant", 32'(bus.DoRetire), 32'h0);
        check("rr_reg3", 32'(bus.wb_register), 32'd3);
        check("rr_value3", bus.wb_value, 32'h102);
        check("rr_count3a", bus.retired_count, 32'd2);
        cyc(); #1;
        check("rr_count3", bus.retired_count, 32'd3);
        check("rr_empty", 32'(bus.wb_valid), 32'h0);

        // Stall: FULL with wb_ready low holds the entry and blocks grants
        bus.ReadyToRetire = 3'b010;
        bus.wb_ready      = 1'b0;
        #1;
        check("st_first_grant", 32'(bus.DoRetire), 32'b010);
        cyc();
        bus.retire_write_value_units[1] = 32'h1AB;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("st_doretire", 32'(bus.DoRetire), 32'h0);
            check("st_valid", 32'(bus.wb_valid), 32'h1);
            check("st_reg", 32'(bus.wb_register), 32'd2);
            check("st_value", bus.wb_value, 32'h101);
            if (i < 3) begin
                cyc(); #1;
            end
        end
        bus.wb_ready = 1'b1;
        #1;
        check("st_release_grant", 32'(bus.DoRetire), 32'b010);
        cyc();
        bus.ReadyToRetire = 3'b000;
        #1;
        check("st_b2b_valid", 32'(bus.wb_valid), 32'h1);
        check("st_b2b_value", bus.wb_value, 32'h1AB);
        check("st_b2b_count", bus.retired_count, 32'd4);
        cyc(); #1;
        check("st_drain_count", bus.retired_count, 32'd5);

        // x0 destination: retired but write strobe suppressed
        bus.retire_write_units[2]       = 5'd0;
        bus.retire_write_value_units[2] = 32'hDEADBEEF;
        bus.ReadyToRetire = 3'b100;
        bus.wb_ready      = 1'b0;
        #1;
        check("x0_grant", 32'(bus.DoRetire), 32'b100);
        cyc();
        bus.ReadyToRetire = 3'b000;
        bus.retire_write_units[2]       = 5'd3;
        bus.retire_write_value_units[2] = 32'h102;
        #1;
        check("x0_valid", 32'(bus.wb_valid), 32'h1);
        check("x0_we", 32'(bus.wb_write_enable), 32'h0);
        check("x0_reg", 32'(bus.wb_register), 32'd0);
        check("x0_value", bus.wb_value, 32'hDEADBEEF);

        // Flush while FULL and stalled
        bus.flush         = 1'b1;
        bus.ReadyToRetire = 3'b001;
        #1;
        check("fl_nogrant", 32'(bus.DoRetire), 32'h0);
        cyc();
        bus.flush = 1'b0;
        #1;
        check("fl_valid", 32'(bus.wb_valid), 32'h0);
        check("fl_we", 32'(bus.wb_write_enable), 32'h0);
        check("fl_next_grant", 32'(bus.DoRetire), 32'b001);
        cyc();
        bus.ReadyToRetire = 3'b000;
        #1;
        check("fl_load_reg", 32'(bus.wb_register), 32'd1);
        check("fl_load_we", 32'(bus.wb_write_enable), 32'h1);
        check("fl_count", bus.retired_count, 32'd5);
        bus.flush    = 1'b1;
        bus.wb_ready = 1'b1;
        bus.ReadyToRetire = 3'b001;
        #1;
        check("fl_acc_nogrant", 32'(bus.DoRetire), 32'h0);
        cyc();
        bus.flush = 1'b0;
        bus.ReadyToRetire = 3'b000;
        #1;
        check("fl_acc_count", bus.retired_count, 32'd6);
        check("fl_acc_valid", 32'(bus.wb_valid), 32'h0);

        // Two continuous requesters alternate
        bus.ReadyToRetire = 3'b101;
        #1;
        check("alt_g0", 32'(bus.DoRetire), 32'b100);
        cyc(); #1;
        check("alt_reg", 32'(bus.wb_register), 32'd3);
        check("alt_g1", 32'(bus.DoRetire), 32'b001);
        cyc(); #1;
        check("alt_g2", 32'(bus.DoRetire), 32'b100);
        cyc(); #1;
        check("alt_g3", 32'(bus.DoRetire), 32'b001);
        cyc(); #1;
        check("alt_g4", 32'(bus.DoRetire), 32'b100);
        cyc();
        bus.ReadyToRetire = 3'b000;
        #1;
        check("alt_count", bus.retired_count, 32'd10);
        cyc(); #1;
        check("alt_drain", bus.retired_count, 32'd11);

        // Asynchronous reset between edges while FULL
        bus.ReadyToRetire = 3'b001;
        bus.wb_ready      = 1'b0;
        #1;
        check("ar_grant", 32'(bus.DoRetire), 32'b001);
        cyc();
        #1;
        check("ar_full", 32'(bus.wb_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(bus.wb_valid), 32'h0);
        check("ar_doretire", 32'(bus.DoRetire), 32'h0);
        check("ar_count", bus.retired_count, 32'd0);
        check("ar_reg", 32'(bus.wb_register), 32'd0);
        rst_n = 1'b1;
        #1;
        check("ar_rerequest", 32'(bus.DoRetire), 32'b001);
        cyc(); #1;
        check("ar_reload", 32'(bus.wb_valid), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/retire_scheduler.md
Name: retire_scheduler

Overview:
- Round-robin retirement scheduler between the reservation stations and the register-file write port.
- Each cycle it picks one station asserting ReadyToRetire, acknowledges it with DoRetire, and captures that station's write fields into a one-entry writeback stage.
- The stage presents valid/ready to the register-file port, which may stall when issue-side writes take the port.
- Replaces fixed-priority retirement so that no station can be starved.

Parameters:
- RS_COUNT, 3, number of reservation stations (2..8).
- REG_ADDR_W, 5, architectural register index width.
- DATA_W, 32, register value width (matches the register type).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ReadyToRetire  input  RS_COUNT  per-station request to retire.
- retire_write_enable_units  input  RS_COUNT  per-station writeback enable.
- retire_write_units  input  RS_COUNT x REG_ADDR_W  per-station destination register.
- retire_write_value_units  input  RS_COUNT x DATA_W  per-station result value.
- DoRetire  output  RS_COUNT  one-hot grant; the station frees itself on the clock edge where its bit is high.
- flush  input  1  pipeline flush; discards the stage and blocks any grant this cycle.
- wb_valid  output  1  writeback stage holds an entry.
- wb_ready  input  1  register-file port accepts the entry this cycle.
- wb_write_enable  output  1  register write strobe for the held entry.
- wb_register  output  REG_ADDR_W  destination register of the held entry.
- wb_value  output  DATA_W  value of the held entry.
- retired_count  output  32  count of entries accepted by the port (wb_valid && wb_ready).

Behaviour:
- Reset (rst_n low, asynchronous): wb_valid=0, wb_write_enable=0, wb_register=0, wb_value=0, rr_ptr=0, retired_count=0. DoRetire=0 while rst_n is low.
- State is the stage valid bit: EMPTY (wb_valid=0) or FULL (wb_valid=1).
- accept = wb_valid && wb_ready.
- can_load = !flush && (!wb_valid || accept).
- Arbitration (combinational, Mealy):
  - Scan indices rr_ptr, rr_ptr+1, ... modulo RS_COUNT.
  - The winner is the first index with ReadyToRetire set.
  - DoRetire = one-hot(winner) if can_load and any request is set; otherwise 0.
  - DoRetire never has more than one bit set.
- Load (clock edge with a grant):
  - Stage captures the winner's write_enable, register and value; wb_valid becomes 1.
  - rr_ptr <= (winner+1) mod RS_COUNT.
- x0 rule: if the captured register is 0, wb_write_enable is stored as 0. The station is still retired and the entry still passes through the handshake.
- Transitions:
  - EMPTY with grant -> FULL.
  - EMPTY with no grant -> EMPTY.
  - FULL with !wb_ready -> FULL. All wb_* outputs hold stable; DoRetire=0.
  - FULL with accept and a grant -> FULL with the new entry (back-to-back, one retire per cycle).
  - FULL with accept and no grant -> EMPTY.
- flush: on the next edge wb_valid=0 and wb_write_enable=0. No grant is issued that cycle and rr_ptr is unchanged. If accept coincides with flush, the accept still counts, since the port sampled it.
- retired_count increments by 1 on every accept and wraps at 2^32.
- Latency: request-to-DoRetire is 0 cycles when the stage can load. Grant-to-wb_valid is 1 cycle.
- Fairness: a station holding ReadyToRetire high is granted within RS_COUNT grants.
- Request changes while FULL and stalled have no effect until can_load.
- The scheduler does not check write-after-write hazards between stations; the issue logic guarantees ordering.
- rst_n asserted mid-transfer drops the entry. Stations re-request after reset.

Test Plan:
- Reset, then ReadyToRetire=3'b111 with wb_ready=1 held for 3 cycles -> DoRetire sequence 001, 010, 100; wb_register follows the stations' values; retired_count=3 one cycle later.
- Stage FULL with wb_ready=0 for 4 cycles, ReadyToRetire=3'b010 -> DoRetire=0 throughout; wb_* stable; wb_ready=1 -> station 1 granted the same cycle; back-to-back load.
- Station 2 captures register 0, write_enable=1, value 32'hDEADBEEF -> wb_valid=1, wb_write_enable=0, station 2 retired.
- Stage FULL, flush=1 with ReadyToRetire=3'b001 -> DoRetire=0; wb_valid=0 next cycle; rr_ptr unchanged; station 0 granted on the following cycle.
- Stations 0 and 2 requesting continuously, rr_ptr=0 -> grants alternate 0, 2, 0, 2; station 2 never waits more than 1 grant.
- rst_n pulsed low asynchronously between edges while FULL -> wb_valid=0 and DoRetire=0 immediately; retired_count=0.
